// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
//   mem_state_t : FIRST issues the (pointer or single) access, SECOND the
//                 data access of an indirect op.
//   BE_*        : data-memory byte-lane masks, bit1 = high byte.
package mem_stage_ctrl_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } mem_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus.
//   master : controller side, drives address/wdata/strobes/byte_enable
//   slave  : memory side, returns a one-cycle dmem_resp with dmem_rdata
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] dmem_address;
  logic [ADDR_W-1:0] dmem_wdata;
  logic              dmem_read;
  logic              dmem_write;
  logic [1:0]        dmem_byte_enable;
  logic              dmem_resp;
  logic [ADDR_W-1:0] dmem_rdata;

  modport master (
    output dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_address, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Byte-lane steering for LDB/STB (combinational).
//   byte_acc    : current access is a byte access
//   lane_sel    : address bit0, 1 = high byte
//   store_data  : store operand from EX
//   rdata       : raw memory read word
//   byte_enable : lane mask to memory
//   wdata       : store data, low byte replicated into every lane for bytes
//   load_data   : read word, or selected byte zero-extended
module mem_byte_lane
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              byte_acc,
  input  logic              lane_sel,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [ADDR_W-1:0] rdata,
  output logic [1:0]        byte_enable,
  output logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] load_data
);

  always_comb begin
    byte_enable = BE_WORD;
    wdata       = store_data;
    load_data   = rdata;
    if (byte_acc) begin
      byte_enable = lane_sel ? BE_HI : BE_LO;
      // replicate so the memory sees the byte on whichever lane is enabled
      wdata       = {(ADDR_W/8){store_data[7:0]}};
      load_data   = '0;
      load_data[7:0] = lane_sel ? rdata[15:8] : rdata[7:0];
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller, between the EX/MEM and MEM/WB registers.
// Sequences single loads/stores and LDI/STI (pointer fetch, then data access
// at the fetched pointer), steers byte lanes, and stalls upstream while an
// access is outstanding.
//   clk, reset_n        : clock, async active-low reset
//   mem_*               : EX/MEM slot (valid, address, alu/store data, dest, controls)
//   dmem                : data-memory bus (master)
//   mem_stall           : hold EX/MEM and earlier stages
//   wb_*                : MEM/WB register outputs
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [ADDR_W-1:0] mem_alu_out,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_indirect,
  input  logic              mem_byte,
  mem_stage_ctrl_if.master  dmem,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_from_mem
);

  mem_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] access_addr;
  logic [ADDR_W-1:0] load_data;
  logic [ADDR_W-1:0] lane_wdata;
  logic [1:0]        lane_be;
  logic              op, fetch, final_acc, byte_acc;
  logic              rd_strobe, wr_strobe, resp_ok, complete;

  assign op        = mem_valid & (mem_read | mem_write);
  // first half of LDI/STI: always a word read of the pointer
  assign fetch     = (state == FIRST) & mem_indirect;
  assign final_acc = ~fetch;
  assign byte_acc  = mem_byte & final_acc;
  assign access_addr = (state == SECOND) ? ptr : mem_address;

  mem_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
    .byte_acc    (byte_acc),
    .lane_sel    (access_addr[0]),
    .store_data  (mem_alu_out),
    .rdata       (dmem.dmem_rdata),
    .byte_enable (lane_be),
    .wdata       (lane_wdata),
    .load_data   (load_data)
  );

  // Strobes gated by reset_n so an in-flight access is dropped the moment
  // reset asserts. Read wins if both controls are ever set.
  assign rd_strobe = reset_n & op & (fetch | mem_read);
  assign wr_strobe = reset_n & op & final_acc & mem_write & ~mem_read;

  assign dmem.dmem_address     = {access_addr[ADDR_W-1:1], 1'b0};
  assign dmem.dmem_byte_enable = lane_be;
  assign dmem.dmem_wdata       = lane_wdata;
  assign dmem.dmem_read        = rd_strobe;
  assign dmem.dmem_write       = wr_strobe;

  // a response with no strobe up is stray and ignored
  assign resp_ok   = dmem.dmem_resp & (rd_strobe | wr_strobe);
  assign complete  = resp_ok & final_acc;
  assign mem_stall = reset_n & op & ~complete;

  always_comb begin
    state_nxt = state;
    case (state)
      FIRST:   if (resp_ok && fetch) state_nxt = SECOND;
      SECOND:  if (resp_ok || !op)   state_nxt = FIRST;
      default: state_nxt = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FIRST;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (resp_ok && fetch) ptr <= dmem.dmem_rdata;
    end
  end

  // MEM/WB register: bubbles hold data/dest, only wb_valid drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_dest     <= '0;
      wb_from_mem <= 1'b0;
    end else if (op) begin
      wb_valid <= complete;
      if (complete) begin
        wb_data     <= mem_read ? load_data : mem_alu_out;
        wb_dest     <= mem_dest;
        wb_from_mem <= mem_read;
      end
    end else if (mem_valid) begin
      wb_valid    <= 1'b1;
      wb_data     <= mem_alu_out;
      wb_dest     <= mem_dest;
      wb_from_mem <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_read, mem_write, mem_indirect, mem_byte;
  logic [15:0] mem_address, mem_alu_out;
  logic [2:0]  mem_dest;
  logic        mem_stall, wb_valid, wb_from_mem;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;

  int checks = 0;
  int errors = 0;

  // reference memory: word array keyed by aligned address
  logic [15:0] mem [logic [15:0]];

  mem_stage_ctrl_if #(.ADDR_W(16)) dmem_bus ();

  mem_stage_ctrl #(.ADDR_W(16), .REG_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_valid    (mem_valid),
    .mem_address  (mem_address),
    .mem_alu_out  (mem_alu_out),
    .mem_dest     (mem_dest),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_indirect (mem_indirect),
    .mem_byte     (mem_byte),
    .dmem         (dmem_bus.master),
    .mem_stall    (mem_stall),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_from_mem  (wb_from_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [15:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return wa ^ 16'h5A3C;
  endfunction

  task automatic drive(input bit v, rd, wr, ind, byt, input logic [15:0] a, alu,
                       input logic [2:0] d);
    mem_valid = v; mem_read = rd; mem_write = wr; mem_indirect = ind;
    mem_byte = byt; mem_address = a; mem_alu_out = alu; mem_dest = d;
  endtask

  // Issue one load/store and act as the memory. latN = idle cycles before
  // the response of access N (0 = response in the issue cycle).
  task automatic run_op(input bit rd, wr, ind, byt, input logic [15:0] addr, alu,
                        input logic [2:0] dest, input int lat1, lat2);
    logic [15:0] a, ptr, exp_addr, exp_wd, exp_res, old, rv;
    logic [1:0]  exp_be;
    bit          fin, isb, exp_rd, exp_wr, resp;
    int          lat;
    ptr = '0; exp_res = '0;
    drive(1, rd, wr, ind, byt, addr, alu, dest);
    for (int ph = 0; ph < (ind ? 2 : 1); ph++) begin
      fin      = !ind || ph == 1;
      a        = (ind && fin) ? ptr : addr;
      exp_addr = {a[15:1], 1'b0};
      isb      = byt && fin;
      exp_be   = isb ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
      exp_rd   = !fin || rd;
      exp_wr   = fin && wr;
      exp_wd   = isb ? {alu[7:0], alu[7:0]} : alu;
      lat      = (ph == 0) ? lat1 : lat2;
      for (int c = 0; c <= lat; c++) begin
        resp = (c == lat);
        rv   = (resp && exp_rd) ? mem_rd(exp_addr) : 16'($urandom);
        dmem_bus.dmem_resp  = resp;
        dmem_bus.dmem_rdata = rv;
        #1;
        checks++;
        if (dmem_bus.dmem_address !== exp_addr) begin
          errors++; $display("FAIL addr ph%0d: got %h want %h", ph, dmem_bus.dmem_address, exp_addr);
        end
        checks++;
        if (dmem_bus.dmem_byte_enable !== exp_be) begin
          errors++; $display("FAIL be ph%0d: got %b want %b", ph, dmem_bus.dmem_byte_enable, exp_be);
        end
        checks++;
        if (dmem_bus.dmem_read !== exp_rd || dmem_bus.dmem_write !== exp_wr) begin
          errors++; $display("FAIL strobes ph%0d: got r%b w%b want r%b w%b", ph,
                             dmem_bus.dmem_read, dmem_bus.dmem_write, exp_rd, exp_wr);
        end
        if (exp_wr) begin
          checks++;
          if (dmem_bus.dmem_wdata !== exp_wd) begin
            errors++; $display("FAIL wdata: got %h want %h", dmem_bus.dmem_wdata, exp_wd);
          end
        end
        checks++;
        if (mem_stall !== !(fin && resp)) begin
          errors++; $display("FAIL stall ph%0d c%0d: got %b want %b", ph, c, mem_stall, !(fin && resp));
        end
        if (resp && !fin) ptr = rv;
        if (resp && fin && exp_rd)
          exp_res = isb ? {8'h00, (a[0] ? rv[15:8] : rv[7:0])} : rv;
        if (resp && exp_wr) begin
          old = mem_rd(exp_addr);
          if (!isb)     mem[exp_addr] = alu;
          else if (a[0]) mem[exp_addr] = {alu[7:0], old[7:0]};
          else           mem[exp_addr] = {old[15:8], alu[7:0]};
        end
        @(posedge clk); #1;
        dmem_bus.dmem_resp = 1'b0;
        if (!resp) begin
          checks++;
          if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL bubble: wb_valid got %b want 0", wb_valid);
          end
        end
      end
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_dest !== dest || wb_from_mem !== rd) begin
      errors++; $display("FAIL wb ctl: got v%b d%0d m%b want v1 d%0d m%b",
                         wb_valid, wb_dest, wb_from_mem, dest, rd);
    end
    checks++;
    if (wb_data !== (rd ? exp_res : alu)) begin
      errors++; $display("FAIL wb_data: got %h want %h", wb_data, rd ? exp_res : alu);
    end
  endtask

  task automatic run_alu(input bit v, input logic [15:0] alu, input logic [2:0] d);
    drive(v, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom), alu, d);
    dmem_bus.dmem_resp = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || dmem_bus.dmem_read !== 1'b0 || dmem_bus.dmem_write !== 1'b0) begin
      errors++; $display("FAIL alu strobes: got s%b r%b w%b want 000",
                         mem_stall, dmem_bus.dmem_read, dmem_bus.dmem_write);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== v || (v && (wb_data !== alu || wb_dest !== d || wb_from_mem !== 1'b0))) begin
      errors++; $display("FAIL alu wb: got v%b %h d%0d m%b want v%b %h d%0d m0",
                         wb_valid, wb_data, wb_dest, wb_from_mem, v, alu, d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 1, 0, 0, 0, 16'h1234, 16'h0, 3'd1);
    dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;
    #2;
    checks++;
    if (wb_valid !== 0 || wb_data !== 0 || wb_dest !== 0 || wb_from_mem !== 0) begin
      errors++; $display("FAIL reset wb: got v%b %h d%0d m%b want all 0",
                         wb_valid, wb_data, wb_dest, wb_from_mem);
    end
    checks++;
    if (dmem_bus.dmem_read !== 0 || dmem_bus.dmem_write !== 0 || mem_stall !== 0) begin
      errors++; $display("FAIL reset gate: got r%b w%b s%b want 000",
                         dmem_bus.dmem_read, dmem_bus.dmem_write, mem_stall);
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    run_alu(1, 16'h1234, 3'd3);
    run_alu(0, 16'hFFFF, 3'd5);
    run_alu(1, 16'h0000, 3'd7);
  endtask

  task automatic test_ldr();
    mem[16'h3000] = 16'hBEEF;
    run_op(1, 0, 0, 0, 16'h3001, 16'h0, 3'd2, 2, 0);
  endtask

  task automatic test_stb();
    run_op(0, 1, 0, 1, 16'h2005, 16'h00A7, 3'd4, 2, 0);
    // read back through the model to confirm the lane merge
    run_op(1, 0, 0, 0, 16'h2004, 16'h0, 3'd1, 0, 0);
  endtask

  task automatic test_ldi();
    mem[16'h4000] = 16'h5002;
    mem[16'h5002] = 16'h0042;
    run_op(1, 0, 1, 0, 16'h4000, 16'h0, 3'd6, 1, 2);
    run_op(1, 0, 1, 0, 16'h4000, 16'h0, 3'd6, 0, 0);
  endtask

  task automatic test_ldb();
    mem[16'h6002] = 16'h80FF;
    run_op(1, 0, 0, 1, 16'h6003, 16'h0, 3'd0, 1, 0);
    run_op(1, 0, 0, 1, 16'h6002, 16'h0, 3'd0, 0, 0);
    run_op(1, 0, 0, 1, 16'hFFFF, 16'h0, 3'd0, 0, 0);
  endtask

  task automatic test_reset_mid_sti();
    drive(1, 0, 1, 1, 0, 16'h7000, 16'hCAFE, 3'd2);
    dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 16'h7100;
    @(posedge clk); #1;
    dmem_bus.dmem_resp = 1'b0;
    #1;
    checks++;
    if (dmem_bus.dmem_address !== 16'h7100 || dmem_bus.dmem_write !== 1'b1) begin
      errors++; $display("FAIL sti second: got %h w%b want 7100 w1",
                         dmem_bus.dmem_address, dmem_bus.dmem_write);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (dmem_bus.dmem_write !== 0 || mem_stall !== 0 || wb_valid !== 0) begin
      errors++; $display("FAIL mid reset: got w%b s%b v%b want 000",
                         dmem_bus.dmem_write, mem_stall, wb_valid);
    end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    // stray late response with an empty slot
    dmem_bus.dmem_resp = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 0 || dmem_bus.dmem_read !== 0) begin
      errors++; $display("FAIL stray resp: got s%b r%b want 00", mem_stall, dmem_bus.dmem_read);
    end
    @(posedge clk); #1;
    dmem_bus.dmem_resp = 1'b0;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL stray wb: got v%b want 0", wb_valid);
    end
    mem[16'h3100] = 16'h1357;
    run_op(1, 0, 0, 0, 16'h3100, 16'h0, 3'd5, 1, 0);
  endtask

  task automatic test_random();
    logic [15:0] addr, last;
    int kind;
    last = 16'h0800;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      addr = ($urandom_range(0, 3) == 0) ? last : 16'($urandom_range(0, 31)) | 16'h0800;
      if ($urandom_range(0, 15) == 0) addr = 16'hFFFF;
      last = addr;
      case (kind)
        0:       run_alu($urandom_range(0, 1), 16'($urandom), 3'($urandom));
        1, 2:    run_op(kind == 1, kind == 2, 0, $urandom_range(0, 1), addr, 16'($urandom),
                        3'($urandom), $urandom_range(0, 3), 0);
        3:       run_op(1, 0, 0, 1, addr, 16'($urandom), 3'($urandom), $urandom_range(0, 2), 0);
        default: run_op(kind != 6, kind == 6, 1, $urandom_range(0, 1), addr, 16'($urandom),
                        3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldr();
    test_stb();
    test_ldi();
    test_ldb();
    test_reset_mid_sti();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute bound: every wait above is cycle-counted, this catches anything else
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage access controller. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Consumes the EX/MEM outputs and drives the data-memory request/response port. Sequences single accesses and indirect (LDI/STI) double accesses, and handles byte lanes for LDB/STB.
- Produces the write-back payload and a stall that freezes all upstream pipeline registers while an access is in flight.

Parameters:
- ADDR_W, 16, address and data width (lc3b_word)
- REG_W, 3, destination register index width (lc3b_reg)

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- mem_valid  in  1  EX/MEM slot holds a real instruction
- mem_address  in  16  effective address from EX
- mem_alu_out  in  16  ALU result, or store data for ST/STB/STI
- mem_dest  in  3  destination register
- mem_read  in  1  decoded control: load (LDR/LDB/LDI)
- mem_write  in  1  decoded control: store (STR/STB/STI)
- mem_indirect  in  1  decoded control: LDI/STI
- mem_byte  in  1  decoded control: LDB/STB
- dmem_address  out  16  data-memory address
- dmem_wdata  out  16  data-memory write data
- dmem_read  out  1  read strobe, held until dmem_resp
- dmem_write  out  1  write strobe, held until dmem_resp
- dmem_byte_enable  out  2  lane mask, bit1 = high byte
- dmem_resp  in  1  one-cycle completion pulse
- dmem_rdata  in  16  read data, valid with dmem_resp
- mem_stall  out  1  1 = hold EX/MEM and earlier stages (their load = !mem_stall)
- wb_valid  out  1  MEM/WB slot valid
- wb_data  out  16  load data or forwarded ALU result
- wb_dest  out  3  destination register
- wb_from_mem  out  1  wb_data came from memory

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0:
  - state=FIRST, ptr=0
  - wb_valid=0, wb_data=0, wb_dest=0, wb_from_mem=0
  - dmem_read=0, dmem_write=0, mem_stall=0 (gated combinationally by reset_n)
- Reset asserted mid-access abandons the access immediately. A late dmem_resp after reset release is ignored in FIRST unless a new op is presented.
- op = mem_valid & (mem_read | mem_write).
- State FIRST:
  - If op, drive an access at mem_address. For an indirect op this is always a word read (pointer fetch). Otherwise it is a read or write per control.
  - On dmem_resp for an indirect op: ptr <= dmem_rdata, go to SECOND.
  - On dmem_resp for a non-indirect op: complete.
- State SECOND:
  - Drive the data access at ptr, read or write per control. Strobes stay asserted.
  - On dmem_resp: complete and return to FIRST.
  - mem_valid and the control inputs are stable here because upstream is stalled.
- Strobe stability: strobes and address must stay stable until dmem_resp.
- Stall rule: mem_stall = op & !complete_this_cycle, asserted combinationally.
  - Plain load/store: minimum latency 1 cycle when dmem_resp arrives in the issue cycle.
  - Indirect op: at least 2 cycles.
- Non-memory or invalid slot: no stall. The instruction passes through in one cycle.
- MEM/WB update on each rising edge, computed from the current cycle's inputs:
  - Completing load: wb_valid=1, wb_data=formatted rdata, wb_from_mem=1.
  - Completing store: wb_valid=1, wb_data=mem_alu_out, wb_from_mem=0.
  - Non-memory instruction: wb_valid=mem_valid, wb_data=mem_alu_out, wb_from_mem=0.
  - Stalled cycle: wb_valid=0 (bubble). wb_data and wb_dest hold.
  - wb_dest=mem_dest whenever wb_valid is loaded as 1.
- Word access: dmem_address = {addr[15:1],1'b0}, byte_enable=2'b11, wdata=mem_alu_out.
- Byte access (final access only, never the pointer fetch):
  - byte_enable = addr[0] ? 2'b10 : 2'b01
  - wdata = {mem_alu_out[7:0], mem_alu_out[7:0]}
  - load data = selected byte, zero-extended to 16 bits
- Address wrap: no wrap handling. 16-bit addresses are used unchanged; 0xFFFF as a byte access selects the high lane.
- Pointer formation: ptr uses all 16 bits of dmem_rdata. An odd pointer on a word access is aligned by forcing bit0=0.
- A dmem_resp arriving with no strobe asserted is ignored.

Decomposition:
- lc3b_types gains:
  - mem_state_t enum {FIRST, SECOND}
  - constants BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10
- Byte-lane logic goes in one combinational sub-module, mem_byte_lane: wdata replication, byte_enable, load extraction.
- The FSM, ptr register and MEM/WB output registers stay in mem_stage_ctrl.

Test Plan:
- Reset, then ALU op with mem_valid=1, alu_out=0x1234, dest=3 -> next edge wb_valid=1, wb_data=0x1234, wb_dest=3; mem_stall never 1.
- LDR addr=0x3001, resp after 3 cycles, rdata=0xBEEF:
  - dmem_address=0x3000, be=11 throughout
  - mem_stall=1 for 2 cycles, 0 in the resp cycle
  - then wb_data=0xBEEF, wb_from_mem=1
- STB addr=0x2005, alu_out=0x00A7 -> wdata=0xA7A7, be=10, dmem_write held until resp; afterwards wb_from_mem=0.
- LDI addr=0x4000:
  - first resp rdata=0x5002 -> dmem_address switches to 0x5002
  - second resp rdata=0x0042 -> wb_data=0x0042
  - exactly two read strobes; stall released only in the second resp cycle
- LDB addr=0x6003, rdata=0x80FF -> wb_data=0x0080, be=10.
- STI with reset_n dropped in SECOND -> same cycle dmem_write=0, mem_stall=0, wb_valid=0; after release, a new LDR completes normally.
